// File: rtl/wordle_guess_evaluator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wordle_guess_evaluator_if : request/result bus between the game FSM, the
// guess evaluator and the board tile store.                    rev 1.0
// ---------------------------------------------------------------------------
interface wordle_guess_evaluator_if #(
   parameter int LETTER_W    = 8,
   parameter int NUM_LETTERS = 5
);
   logic                            start;
   logic [LETTER_W*NUM_LETTERS-1:0] guess;
   logic [LETTER_W*NUM_LETTERS-1:0] secret;
   logic [2:0]                      row;
   logic                            busy;
   logic                            done;
   logic                            win;
   logic                            err;
   logic [2*NUM_LETTERS-1:0]        result;
   logic                            tile_we;
   logic [4:0]                      tile_addr;
   logic [1:0]                      tile_data;

   modport master (
      output start, guess, secret, row,
      input  busy, done, win, err, result, tile_we, tile_addr, tile_data
   );

   modport slave (
      input  start, guess, secret, row,
      output busy, done, win, err, result, tile_we, tile_addr, tile_data
   );
endinterface
`default_nettype wire

// File: rtl/wordle_guess_evaluator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wordle_guess_evaluator : scores a 5-letter guess (green/yellow/gray with
// duplicate handling) and writes the colours into the board tile store. rev 1.0
// ---------------------------------------------------------------------------
module wordle_guess_evaluator #(
   parameter int LETTER_W    = 8,
   parameter int NUM_LETTERS = 5,
   parameter int NUM_ROWS    = 6
) (
   input  wire logic               Clk,
   input  wire logic               reset_n,
   wordle_guess_evaluator_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GREEN  = 3'd1,
      S_YELLOW = 3'd2,
      S_WRITE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [1:0] C_GRAY   = 2'b01;
   localparam logic [1:0] C_YELLOW = 2'b10;
   localparam logic [1:0] C_GREEN  = 2'b11;
   localparam logic [2:0] LAST_COL = 3'(NUM_LETTERS - 1);
   localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

   state_t                                    state_q, state_d;
   logic [2:0]                                col_q, col_d;
   logic [2:0]                                j_q, j_d;
   logic [2:0]                                row_q, row_d;
   logic [0:NUM_LETTERS-1][LETTER_W-1:0]      guess_q, guess_d;
   logic [0:NUM_LETTERS-1][LETTER_W-1:0]      secret_q, secret_d;
   logic [0:NUM_LETTERS-1][1:0]               colour_q, colour_d;
   logic [NUM_LETTERS-1:0]                    used_q, used_d;
   logic                                      win_q, win_d;
   logic                                      err_q, err_d;

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         col_q    <= '0;
         j_q      <= '0;
         row_q    <= '0;
         guess_q  <= '0;
         secret_q <= '0;
         colour_q <= '0;
         used_q   <= '0;
         win_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         j_q      <= j_d;
         row_q    <= row_d;
         guess_q  <= guess_d;
         secret_q <= secret_d;
         colour_q <= colour_d;
         used_q   <= used_d;
         win_q    <= win_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      j_d      = j_q;
      row_d    = row_q;
      guess_d  = guess_q;
      secret_d = secret_q;
      colour_d = colour_q;
      used_d   = used_q;
      win_d    = win_q;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.row > LAST_ROW) begin
                  err_d = 1'b1;
               end else begin
                  guess_d  = bus.guess;
                  secret_d = bus.secret;
                  row_d    = bus.row;
                  colour_d = {NUM_LETTERS{C_GRAY}};
                  used_d   = '0;
                  win_d    = 1'b0;
                  col_d    = '0;
                  j_d      = '0;
                  state_d  = S_GREEN;
               end
            end
         end

         S_GREEN: begin
            if (guess_q[col_q] == secret_q[col_q]) begin
               colour_d[col_q] = C_GREEN;
               used_d[col_q]   = 1'b1;
            end
            if (col_q == LAST_COL) begin
               col_d   = '0;
               state_d = S_YELLOW;
            end else begin
               col_d = col_q + 3'd1;
            end
         end

         S_YELLOW: begin
            // A letter still gray has neither a green nor a yellow match yet,
            // so the gray test doubles as the "first match only" guard.
            if (colour_q[col_q] == C_GRAY && !used_q[j_q] &&
                guess_q[col_q] == secret_q[j_q]) begin
               colour_d[col_q] = C_YELLOW;
               used_d[j_q]     = 1'b1;
            end
            if (j_q == LAST_COL) begin
               j_d = '0;
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = S_WRITE;
               end else begin
                  col_d = col_q + 3'd1;
               end
            end else begin
               j_d = j_q + 3'd1;
            end
         end

         S_WRITE: begin
            if (col_q == LAST_COL) begin
               col_d   = '0;
               win_d   = (colour_q == {NUM_LETTERS{C_GREEN}});
               state_d = S_DONE;
            end else begin
               col_d = col_q + 3'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.win       = win_q;
   assign bus.err       = err_q;
   assign bus.result    = colour_q;
   assign bus.tile_we   = (state_q == S_WRITE);
   assign bus.tile_addr = bus.tile_we ?
                          ({2'b00, row_q} * 5'd5 + {2'b00, col_q}) : 5'd0;
   assign bus.tile_data = bus.tile_we ? colour_q[col_q] : 2'b00;

endmodule
`default_nettype wire
